// File: rtl/rv32i_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_regfile_wb_arbiter
// Purpose  : Shares the register-file write port between the ALU (req0) and
//            the load unit (req1) using round-robin arbitration. The winning
//            write is registered onto rf_we/rf_rd/rf_data. The module also
//            keeps a pending-write scoreboard that the issue stage queries
//            for RAW/WAW hazards.
// Ports    : sys_clk, sys_reset      - clock, synchronous active-high reset
//            reqN_valid/rd/data/ready - writeback requesters (ready is comb)
//            rf_we/rf_rd/rf_data     - registered register-file write port
//            alloc_valid/rd/ready    - scoreboard allocation (ready is comb)
//            rs1/rs2 -> rs1_busy/rs2_busy - combinational hazard queries
//            conflict_cnt            - only with RF_WB_CONFLICT_CNT_EN defined
// Options  : RF_WB_CONFLICT_CNT_EN adds a saturating 16-bit count of edges
//            at which both requesters were valid.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic            sys_clk,
  input  logic            sys_reset,
  input  logic            req0_valid,
  input  logic [RW-1:0]   req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [RW-1:0]   req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  output logic            rf_we,
  output logic [RW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_data,
  input  logic            alloc_valid,
  input  logic [RW-1:0]   alloc_rd,
  output logic            alloc_ready,
  input  logic [RW-1:0]   rs1,
  input  logic [RW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy
`ifdef RF_WB_CONFLICT_CNT_EN
  ,
  output logic [15:0]     conflict_cnt
`endif
);

  // last_grant_q = 1 means req1 won the last conflict, so req0 wins the next.
  logic             last_grant_q, last_grant_d;
  logic             rf_we_q, rf_we_d;
  logic [RW-1:0]    rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]  rf_data_q, rf_data_d;
  logic [NREGS-1:0] busy_q, busy_d;

  logic             w_grant0, w_grant1;
  logic [RW-1:0]    w_win_rd;
  logic [XLEN-1:0]  w_win_data;

  always_comb begin
    w_grant0 = req0_valid & (~req1_valid | last_grant_q);
    w_grant1 = req1_valid & (~req0_valid | ~last_grant_q);

    // Priority only rotates when there was an actual conflict.
    last_grant_d = last_grant_q;
    if (req0_valid && req1_valid) begin
      last_grant_d = w_grant1;
    end

    w_win_rd   = w_grant1 ? req1_rd   : req0_rd;
    w_win_data = w_grant1 ? req1_data : req0_data;

    // Writes to x0 are accepted but never reach the file.
    rf_we_d   = (w_grant0 | w_grant1) & (w_win_rd != '0);
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (w_grant0 || w_grant1) begin
      rf_rd_d   = w_win_rd;
      rf_data_d = w_win_data;
    end

    alloc_ready = ~busy_q[alloc_rd] | (alloc_rd == '0);

    // Clear is applied first so a same-index set wins.
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_rd_q] = 1'b0;
    end
    if (alloc_valid && alloc_ready && (alloc_rd != '0)) begin
      busy_d[alloc_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      last_grant_q <= 1'b1;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_data_q    <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_data_q    <= rf_data_d;
      busy_q       <= busy_d;
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_data    = rf_data_q;
  assign rs1_busy   = busy_q[rs1];
  assign rs2_busy   = busy_q[rs2];

`ifdef RF_WB_CONFLICT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (req0_valid && req1_valid && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32i_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_regfile_wb_arbiter
// Purpose  : Self-checking bench for rv32i_regfile_wb_arbiter. Directed
//            scenarios followed by randomized traffic, all checked against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_regfile_wb_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_reset;
  logic        req0_valid, req1_valid, alloc_valid;
  logic [4:0]  req0_rd, req1_rd, alloc_rd, rs1, rs2;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, rf_we, alloc_ready, rs1_busy, rs2_busy;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
`ifdef RF_WB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  always #5 sys_clk = ~sys_clk;

  rv32i_regfile_wb_arbiter dut (
    .sys_clk     (sys_clk),
    .sys_reset   (sys_reset),
    .req0_valid  (req0_valid),
    .req0_rd     (req0_rd),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_rd     (req1_rd),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_data     (rf_data),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .alloc_ready (alloc_ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy)
`ifdef RF_WB_CONFLICT_CNT_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pending set, last committed write, who wins next tie.
  bit [31:0] m_busy;
  bit        m_we;
  bit [4:0]  m_rd;
  bit [31:0] m_data;
  int        m_pref;   // 0 -> req0 wins next conflict, 1 -> req1
  int        m_cnt;
  bit        g0, g1;   // model's grants of the last cycle

  task automatic clr_inputs();
    sys_reset   = 1'b0;
    req0_valid  = 1'b0; req0_rd = '0; req0_data = '0;
    req1_valid  = 1'b0; req1_rd = '0; req1_data = '0;
    alloc_valid = 1'b0; alloc_rd = '0;
    rs1 = '0; rs2 = '0;
  endtask

  // Called at a falling edge with inputs already driven; checks the
  // combinational outputs, advances one clock, checks registered outputs.
  task automatic cyc();
    bit e0, e1, ea;
    #1;
    if (req0_valid && req1_valid) begin
      e0 = (m_pref == 0);
      e1 = (m_pref == 1);
    end else begin
      e0 = req0_valid;
      e1 = req1_valid;
    end
    ea = (m_busy[alloc_rd] == 1'b0) || (alloc_rd == 5'd0);
    chk("req0_ready",  32'(req0_ready),  32'(e0));
    chk("req1_ready",  32'(req1_ready),  32'(e1));
    chk("alloc_ready", 32'(alloc_ready), 32'(ea));
    chk("rs1_busy",    32'(rs1_busy),    32'(m_busy[rs1]));
    chk("rs2_busy",    32'(rs2_busy),    32'(m_busy[rs2]));
    g0 = e0;
    g1 = e1;
    @(posedge sys_clk);
    if (sys_reset) begin
      m_busy = '0; m_we = 0; m_rd = '0; m_data = '0; m_pref = 0; m_cnt = 0;
    end else begin
      if (m_we) m_busy[m_rd] = 1'b0;
      if (alloc_valid && ea && alloc_rd != 5'd0) m_busy[alloc_rd] = 1'b1;
      if (req0_valid && req1_valid) begin
        m_pref = e0 ? 1 : 0;
        if (m_cnt < 65535) m_cnt++;
      end
      if (e0) begin
        m_we = (req0_rd != 5'd0); m_rd = req0_rd; m_data = req0_data;
      end else if (e1) begin
        m_we = (req1_rd != 5'd0); m_rd = req1_rd; m_data = req1_data;
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
    chk("rf_we",   32'(rf_we), 32'(m_we));
    chk("rf_rd",   32'(rf_rd), 32'(m_rd));
    chk("rf_data", rf_data,    m_data);
`ifdef RF_WB_CONFLICT_CNT_EN
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
`endif
    @(negedge sys_clk);
  endtask

  bit        p0v, p1v;
  bit [4:0]  p0rd, p1rd;
  bit [31:0] p0d, p1d;

  initial begin
    clr_inputs();
    m_busy = '0; m_we = 0; m_rd = '0; m_data = '0; m_pref = 0; m_cnt = 0;
    @(negedge sys_clk);

    // Reset and reset state.
    sys_reset = 1'b1;
    cyc();
    cyc();
    chk("rst_we",   32'(rf_we), 32'd0);
    chk("rst_data", rf_data,    32'd0);
    clr_inputs();

    // Single req0 write to x5.
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'h25;
    cyc();
    chk("t1_we",   32'(rf_we), 32'd1);
    chk("t1_rd",   32'(rf_rd), 32'd5);
    chk("t1_data", rf_data,    32'h25);
    clr_inputs();
    cyc();

    // Four conflict cycles; loser holds its request.
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_rd = 5'd1; req0_data = 32'h101; req1_rd = 5'd2; req1_data = 32'h202;
    cyc();
    chk("alt0_data", rf_data, 32'h101);
    req0_rd = 5'd3; req0_data = 32'h303;
    cyc();
    chk("alt1_data", rf_data, 32'h202);
    req1_rd = 5'd4; req1_data = 32'h404;
    cyc();
    chk("alt2_data", rf_data, 32'h303);
    req0_rd = 5'd1; req0_data = 32'h111;
    cyc();
    chk("alt3_data", rf_data, 32'h404);
    clr_inputs();

    // Write to x0 from req1 is accepted but dropped.
    req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'hDEAD;
    cyc();
    chk("x0_we", 32'(rf_we), 32'd0);
    clr_inputs();

    // Allocation / WAW stall / clear after writeback.
    alloc_valid = 1'b1; alloc_rd = 5'd7; rs1 = 5'd7;
    cyc();
    cyc();                              // second alloc of x7 must stall
    alloc_valid = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h77;
    cyc();
    req0_valid = 1'b0;
    cyc();                              // rf_we cycle: still busy
    cyc();                              // now clear
    alloc_valid = 1'b1;
    cyc();                              // re-alloc of x7 accepted
    clr_inputs();

    // Set of x3 concurrent with clear of x9.
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    cyc();
    alloc_valid = 1'b0;
    req1_valid = 1'b1; req1_rd = 5'd9; req1_data = 32'h99;
    cyc();
    req1_valid = 1'b0;
    alloc_valid = 1'b1; alloc_rd = 5'd3; rs1 = 5'd3; rs2 = 5'd9;
    cyc();
    alloc_valid = 1'b0;
    cyc();
    clr_inputs();

    // Reset in the rf_we cycle of a pending write.
    alloc_valid = 1'b1; alloc_rd = 5'd10; rs1 = 5'd10;
    cyc();
    alloc_valid = 1'b0;
    req1_valid = 1'b1; req1_rd = 5'd10; req1_data = 32'hA0;
    cyc();
    req1_valid = 1'b0;
    sys_reset = 1'b1;
    cyc();
    chk("rstmid_we", 32'(rf_we), 32'd0);
    sys_reset = 1'b0;
    alloc_rd = 5'd10;
    req0_valid = 1'b1; req0_rd = 5'd11; req0_data = 32'hB0;
    req1_valid = 1'b1; req1_rd = 5'd12; req1_data = 32'hC0;
    cyc();
    chk("rstmid_grant", rf_data, 32'hB0);
    clr_inputs();

    // Randomized traffic with a handshake-respecting driver.
    p0v = 0; p1v = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!p0v && ($urandom_range(2) != 0)) begin
        p0v = 1; p0rd = 5'($urandom_range(15)); p0d = $urandom;
      end
      if (!p1v && ($urandom_range(2) != 0)) begin
        p1v = 1; p1rd = 5'($urandom_range(15)); p1d = $urandom;
      end
      req0_valid = p0v; req0_rd = p0rd; req0_data = p0d;
      req1_valid = p1v; req1_rd = p1rd; req1_data = p1d;
      alloc_valid = ($urandom_range(1) == 0);
      alloc_rd    = 5'($urandom_range(15));
      rs1         = 5'($urandom_range(15));
      rs2         = 5'($urandom_range(15));
      sys_reset   = ($urandom_range(63) == 0);
      cyc();
      if (!sys_reset) begin
        if (g0) p0v = 0;
        if (g1) p1v = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv32i_regfile_wb_arbiter.md
Name: rv32i_regfile_wb_arbiter

Overview:
Shares the single write port of the RV32I register file between two writeback sources. Requester 0 is the ALU/execute stage; requester 1 is the load unit. Uses a valid/ready handshake with round-robin arbitration and registers the winning write onto the file's indata/rd/we inputs. Also holds a 32-entry pending-write scoreboard, which the issue stage uses for RAW/WAW hazard detection on rs1/rs2/rd.

Parameters:
XLEN, 32, data width of writeback and register file
NREGS, 32, number of architectural registers (rd/rs index width = $clog2(NREGS) = 5)

Ports:
sys_clk  in  1  clock, all state updates on rising edge
sys_reset  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 (ALU) has a write
req0_rd  in  5  destination index
req0_data  in  XLEN  write data
req0_ready  out  1  requester 0 accepted this cycle (combinational)
req1_valid  in  1  requester 1 (load) has a write
req1_rd  in  5  destination index
req1_data  in  XLEN  write data
req1_ready  out  1  requester 1 accepted this cycle (combinational)
rf_we  out  1  to register file we (registered)
rf_rd  out  5  to register file rd (registered)
rf_data  out  XLEN  to register file indata (registered)
alloc_valid  in  1  issue stage marks alloc_rd as pending
alloc_rd  in  5  register being allocated
alloc_ready  out  1  allocation accepted (combinational)
rs1  in  5  hazard query index 1
rs2  in  5  hazard query index 2
rs1_busy  out  1  busy[rs1] (combinational)
rs2_busy  out  1  busy[rs2] (combinational)

Behaviour:
- Clock and reset: one clock, sys_clk. sys_reset is synchronous, active-high; it wins over all other inputs at that edge.
- Reset values:
  - rf_we=0, rf_rd=0, rf_data=0.
  - busy[31:0]=0.
  - last_grant=1, so requester 0 has priority on the first conflict.
- Arbitration, combinational, same cycle:
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - reqN_ready = grantN. The other ready stays 0; the loser must hold valid/rd/data stable.
  - last_grant updates only on a both-valid conflict cycle.
- Write stage, at the edge after the grant:
  - rf_we <= (granted AND granted rd != 0); rf_rd <= granted rd; rf_data <= granted data.
  - Latency is accept edge to rf_we high: 1 cycle. The register file commits on the following edge.
  - No grant: rf_we <= 0; rf_rd/rf_data hold their values.
- rd = 0: the write is still accepted (ready=1) but dropped (rf_we stays 0). No busy effect.
- Scoreboard set:
  - alloc_ready = alloc_valid-independent: (busy[alloc_rd]==0) OR (alloc_rd==0).
  - alloc_valid & alloc_ready & alloc_rd!=0 -> busy[alloc_rd] <= 1 at the edge.
  - A WAW on a pending rd stalls the issue stage via alloc_ready=0.
- Scoreboard clear: at an edge where rf_we=1, busy[rf_rd] <= 0. busy therefore drops the cycle after the file has committed the data.
- Simultaneous set and clear:
  - Different indices: both take effect.
  - Same index: set wins. This is only reachable when alloc_ready was 1, i.e. the bit was already clear.
- Clearing a non-busy bit is a no-op.
- busy[0] is always 0; rs1_busy/rs2_busy are 0 for index 0.
- The scoreboard does not check requester rd against busy; writes to non-allocated rd are legal.
- Reset mid-operation:
  - An in-flight rf_we is squashed (rf_we=0 next cycle).
  - Pending grants are lost; requesters must re-present after reset.
  - All busy bits clear.

Optional Feature:
RF_WB_CONFLICT_CNT_EN:
- Defined: adds output conflict_cnt [15:0].
  - Increments at each edge where req0_valid & req1_valid.
  - Saturates at 16'hFFFF.
  - Reset to 0.
- Not defined: no port, no counter logic; all other behaviour is identical.

Test Plan:
- Reset, then req0 only, rd=5, data=32'h25 -> req0_ready=1 same cycle; next cycle rf_we=1, rf_rd=5, rf_data=32'h25; register file reads x5=32'h25 afterwards.
- Both valid for 4 cycles with distinct rds 1..4 -> grants alternate 0,1,0,1; each loser holds; rf_data sequence matches the grant order; conflict_cnt=4 if RF_WB_CONFLICT_CNT_EN.
- req1 valid, rd=0, data=32'hDEAD -> req1_ready=1; rf_we stays 0; register file x0 reads 0.
- alloc rd=7 -> rs1=7 gives rs1_busy=1. A second alloc rd=7 -> alloc_ready=0. req0 writes rd=7: busy stays 1 during the rf_we cycle, 0 the cycle after. Re-alloc rd=7 -> alloc_ready=1.
- alloc rd=3 in the same cycle as rf_we for rd=9 (busy[9]=1) -> busy[3]=1 and busy[9]=0 next cycle.
- Set busy[10] and grant a write; assert sys_reset in the cycle rf_we=1 -> next cycle rf_we=0, rs1_busy(10)=0, alloc_ready=1, and req0 wins the next conflict.
